dual_cam_frame_switch: RTL
==========================

DUAL_CAM_FRAME_SWITCH -- requirements
Module: dual_cam_frame_switch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning width of each camera data bus and of data_out.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16'd60000, meaning the maximum number of clock_in cycles spent waiting for a start of frame before falling back.
REQ-003 The block SHALL have port clock_in, input, 1 bit: the single clock; both camera sources are synchronous to it.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports fv_a, lv_a, input, 1 bit each: camera A frame and line valid.
REQ-006 The block SHALL have port data_a, input, DATA_W bits: camera A pixel data.
REQ-007 The block SHALL have ports fv_b, lv_b, input, 1 bit each, and data_b, input, DATA_W bits: camera B equivalents.
REQ-008 The block SHALL have port enable, input, 1 bit: forwarding permitted.
REQ-009 The block SHALL have port sel_req, input, 1 bit: requested source (0=A, 1=B).
REQ-010 The block SHALL have port alt_mode, input, 1 bit: when high, alternate sources A/B every frame and ignore sel_req.
REQ-011 The block SHALL have port err_clr, input, 1 bit: clears sticky errors.
REQ-012 The block SHALL have ports FV, LV, output, 1 bit each, and data_out, output, DATA_W bits: forwarded stream to the CSI-2 packer.
REQ-013 The block SHALL have port active_sel, output, 1 bit: source currently owning the output.
REQ-014 The block SHALL have port switch_done, output, 1 bit: one-cycle pulse on the first forwarded cycle of a frame from a source different from the previous frame's.
REQ-015 The block SHALL have port frame_count, output, 16 bits: completed forwarded frames.
REQ-016 The block SHALL have ports timeout_err and lv_err, output, 1 bit each: sticky error flags.

Function
REQ-017 The block SHALL register per-source fv history; SOF = fv & ~fv_q, EOF = ~fv & fv_q.
REQ-018 The FSM SHALL use the states IDLE, ARM, WAIT_SOF and STREAM.
REQ-019 In IDLE, when enable=1, the block SHALL load target = (alt_mode ? ~active_sel : sel_req) and go to ARM.
REQ-020 In ARM, the block SHALL go to WAIT_SOF once target fv=0, so that a frame already in progress is never joined mid-frame.
REQ-021 In WAIT_SOF, the block SHALL on target SOF set active_sel=target and go to STREAM, forwarding that same SOF cycle.
REQ-022 In WAIT_SOF, the block SHALL increment a timeout counter every cycle.
REQ-023 If the timeout counter reaches TIMEOUT_CYC, the block SHALL set timeout_err, set target=active_sel, clear the counter and go to ARM.
REQ-024 In STREAM, the block SHALL register FV/LV/data_out from the active source with exactly 1 cycle latency.
REQ-025 In any state other than STREAM, the output registers SHALL be FV=0, LV=0 and data_out=0.
REQ-026 On active EOF in STREAM, the block SHALL increment frame_count, wrapping 16'hFFFF to 0.
REQ-027 On active EOF, if enable=0 the block SHALL go to IDLE; otherwise it SHALL reload target per REQ-019 and go to ARM.
REQ-028 sel_req and alt_mode SHALL be sampled only at the IDLE exit, on EOF, and at timeout; changes mid-frame SHALL have no effect on the current frame.
REQ-029 enable falling mid-frame SHALL NOT truncate the frame; forwarding SHALL stop at that frame's EOF.
REQ-030 If the target equals active_sel, ARM SHALL still wait for fv=0 (this is satisfied immediately after EOF).
REQ-031 Source A fv SHALL be the priority path for the first frame after reset, since active_sel resets to 0.
REQ-032 In alt_mode, a B-frame SHALL follow an A-frame even when B is not in phase; the intervening A frame SHALL be dropped.
REQ-033 switch_done SHALL pulse in the same cycle as the forwarded FV rise when active_sel differs from the source of the last forwarded frame.
REQ-034 The first frame after reset SHALL NOT pulse switch_done.
REQ-035 lv_err SHALL set when the active source lv=1 while its fv=0 during STREAM.
REQ-036 Error flags SHALL be cleared by err_clr; if a set condition and err_clr occur in the same cycle, set SHALL win.

Reset
REQ-037 Synchronous reset SHALL force: state=IDLE, FV=0, LV=0, data_out=0, active_sel=0, switch_done=0, frame_count=0, timeout_err=0, lv_err=0, timeout counter=0, fv history=0.
REQ-038 Reset asserted mid-frame SHALL drop FV/LV to 0 on the next edge; no partial-frame recovery is attempted.

Verification
REQ-039 enable=1, sel_req=0, A frames of 4 lines x 1922 cycles -> FV/LV/data_out mirror A delayed 1 cycle; frame_count=1 after the first EOF; switch_done never pulses.
REQ-040 sel_req toggles 0->1 mid-A-frame -> the A frame completes intact; output stays 0 until the next B SOF; switch_done pulses once with active_sel=1.
REQ-041 enable=1 with B already at mid-frame -> no output until B fv falls and rises again; the first forwarded data equals B's data at that SOF.
REQ-042 alt_mode=1 with A and B frames interleaved -> forwarded sources A,B,A,B; switch_done pulses on every frame; frame_count increments by 1 per frame.
REQ-043 TIMEOUT_CYC=100, target B fv stuck at 0 -> timeout_err=1 after 100 WAIT_SOF cycles; the next A frame is forwarded; err_clr clears timeout_err.
REQ-044 Reset pulsed mid-frame, and frame_count at 16'hFFFF followed by an EOF -> outputs 0 one cycle after reset; frame_count wraps to 0.

Source files
------------

// File: rtl/dual_cam_frame_switch.sv
// Frame-aligned two-camera switch: picks camera A or B on frame boundaries only and
// forwards the chosen stream with one cycle of latency, with sticky error flags.
module dual_cam_frame_switch #(
  parameter int          DATA_W      = 16,
  parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              fv_a,
  input  logic              lv_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              fv_b,
  input  logic              lv_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              enable,
  input  logic              sel_req,
  input  logic              alt_mode,
  input  logic              err_clr,
  output logic              FV,
  output logic              LV,
  output logic [DATA_W-1:0] data_out,
  output logic              active_sel,
  output logic              switch_done,
  output logic [15:0]       frame_count,
  output logic              timeout_err,
  output logic              lv_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    WAIT_SOF = 2'd2,
    STREAM   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        fv_a_q_r, fv_b_q_r;
  logic        target_r;
  logic        have_last_r;
  logic [15:0] tmo_cnt_r;

  logic        sof_a_s, sof_b_s;
  logic        tgt_fv_s, tgt_sof_s;
  logic        act_fv_s, act_fv_q_s, act_lv_s, act_eof_s;
  logic        req_sel_s;
  logic        fwd_sel_s;
  logic        load_target_s, go_stream_s, timeout_s, eof_s, lv_bad_s;

  assign sof_a_s    = fv_a & ~fv_a_q_r;
  assign sof_b_s    = fv_b & ~fv_b_q_r;
  assign tgt_fv_s   = target_r ? fv_b : fv_a;
  assign tgt_sof_s  = target_r ? sof_b_s : sof_a_s;
  assign act_fv_s   = active_sel ? fv_b : fv_a;
  assign act_fv_q_s = active_sel ? fv_b_q_r : fv_a_q_r;
  assign act_lv_s   = active_sel ? lv_b : lv_a;
  assign act_eof_s  = ~act_fv_s & act_fv_q_s;
  assign req_sel_s  = alt_mode ? ~active_sel : sel_req;
  // On the SOF cycle active_sel has not been updated yet, so forward from the target.
  assign fwd_sel_s  = go_stream_s ? target_r : active_sel;
  assign lv_bad_s   = (state_r == STREAM) & act_lv_s & ~act_fv_s;

  // State register.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_s       = state_r;
    load_target_s = 1'b0;
    go_stream_s   = 1'b0;
    timeout_s     = 1'b0;
    eof_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          load_target_s = 1'b1;
          state_s       = ARM;
        end else begin
          state_s = IDLE;
        end
      end
      ARM: begin
        if (!tgt_fv_s) begin
          state_s = WAIT_SOF;
        end else begin
          state_s = ARM;
        end
      end
      WAIT_SOF: begin
        if (tgt_sof_s) begin
          go_stream_s = 1'b1;
          state_s     = STREAM;
        end else if (tmo_cnt_r == (TIMEOUT_CYC - 16'd1)) begin
          timeout_s = 1'b1;
          state_s   = ARM;
        end else begin
          state_s = WAIT_SOF;
        end
      end
      STREAM: begin
        if (act_eof_s) begin
          eof_s = 1'b1;
          if (enable) begin
            load_target_s = 1'b1;
            state_s       = ARM;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STREAM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Source selection, timeout counter, frame counter and error flags.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      fv_a_q_r    <= 1'b0;
      fv_b_q_r    <= 1'b0;
      target_r    <= 1'b0;
      active_sel  <= 1'b0;
      have_last_r <= 1'b0;
      switch_done <= 1'b0;
      tmo_cnt_r   <= 16'd0;
      frame_count <= 16'd0;
      timeout_err <= 1'b0;
      lv_err      <= 1'b0;
    end else begin
      fv_a_q_r <= fv_a;
      fv_b_q_r <= fv_b;

      if (load_target_s) begin
        target_r <= req_sel_s;
      end else if (timeout_s) begin
        target_r <= active_sel;
      end

      // have_last_r suppresses the pulse for the very first frame after reset.
      if (go_stream_s) begin
        active_sel  <= target_r;
        have_last_r <= 1'b1;
        switch_done <= have_last_r & (target_r != active_sel);
      end else begin
        switch_done <= 1'b0;
      end

      if ((state_r == WAIT_SOF) && !go_stream_s && !timeout_s) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end else begin
        tmo_cnt_r <= 16'd0;
      end

      if (eof_s) begin
        frame_count <= frame_count + 16'd1;
      end

      if (timeout_s) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end

      if (lv_bad_s) begin
        lv_err <= 1'b1;
      end else if (err_clr) begin
        lv_err <= 1'b0;
      end
    end
  end

  // Forwarded stream registers, zero whenever no frame is being forwarded.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      FV       <= 1'b0;
      LV       <= 1'b0;
      data_out <= {DATA_W{1'b0}};
    end else if (go_stream_s || (state_r == STREAM)) begin
      FV       <= fwd_sel_s ? fv_b   : fv_a;
      LV       <= fwd_sel_s ? lv_b   : lv_a;
      data_out <= fwd_sel_s ? data_b : data_a;
    end else begin
      FV       <= 1'b0;
      LV       <= 1'b0;
      data_out <= {DATA_W{1'b0}};
    end
  end

endmodule
